sodor_imem_responder: RTL
=========================

SODOR_IMEM_RESPONDER -- requirements
Module: sodor_imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of 32-bit program words; word index = req_addr[5:2].
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013: reset fill value and out-of-range return value.
REQ-003 SHALL have parameter QDEPTH, default 2: response queue entries.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: the core presents a fetch request.
REQ-007 SHALL have port req_ready, output, 1: the responder can accept a request this cycle.
REQ-008 SHALL have port req_addr, input, 32: byte address of the fetch.
REQ-009 SHALL have port resp_valid, output, 1: the queue head holds a response.
REQ-010 SHALL have port resp_ready, input, 1: the core consumes the head.
REQ-011 SHALL have port resp_data, output, 32: instruction word at the head.
REQ-012 SHALL have port resp_err, output, 1: the head request was misaligned or out of range.
REQ-013 SHALL have port load_valid, input, 1: program-load write strobe.
REQ-014 SHALL have port load_idx, input, 4: word index to write.
REQ-015 SHALL have port load_data, input, 32: word to write.
REQ-016 SHALL have port req_count, output, 16: accepted requests, saturating.
REQ-017 SHALL have port err_count, output, 8: accepted erroneous requests, saturating.

Function
REQ-018 A request SHALL be accepted in a cycle when req_valid && req_ready.
REQ-019 req_ready SHALL equal (queue occupancy < QDEPTH); it SHALL NOT depend on resp_ready in the same cycle.
REQ-020 On acceptance, {data, err} SHALL be read from the memory array combinationally and pushed into the queue at that edge, giving resp_valid exactly 1 cycle after acceptance when the queue was empty.
REQ-021 Error SHALL be flagged when req_addr[1:0] != 0 or req_addr[31:6] != 0; out-of-range requests SHALL return NOP_WORD, while misaligned in-range requests SHALL return the word at req_addr[5:2].
REQ-022 A pop SHALL occur when resp_valid && resp_ready; responses SHALL leave in acceptance order.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged; at occupancy 1 the new entry becomes the head on the next cycle.
REQ-024 resp_data and resp_err SHALL remain stable while resp_valid && !resp_ready.
REQ-025 load_valid SHALL write mem[load_idx] at the edge; a same-cycle accepted request to the same index SHALL receive the old word (read-before-write).
REQ-026 Loads SHALL be accepted every cycle, independent of the request/response handshake.
REQ-027 req_count SHALL increment on each acceptance, and err_count on each erroneous acceptance; both SHALL hold at all-ones.
REQ-028 Queue read and write pointers SHALL wrap modulo QDEPTH.

Reset
REQ-029 When reset_n = 0 at an edge, all memory words SHALL become NOP_WORD, and the queue, req_count and err_count SHALL become 0.
REQ-030 During reset, outputs SHALL be resp_valid = 0, resp_data = 0, resp_err = 0 and req_ready = 0; req_ready SHALL be 1 from the first cycle after reset_n rises.
REQ-031 A reset asserted mid-operation SHALL discard queued responses and ignore same-cycle req_valid and load_valid.

Structure
REQ-032 The shared package sodor_mem_pkg SHALL hold NOP_WORD, the DEPTH default, the index-field bit positions and the queue entry typedef {data[31:0], err}.
REQ-033 The queue SHALL be a sub-module sodor_resp_fifo, parameterised on QDEPTH, exposing push, pop, full, empty and head.

Verification
REQ-034 Reset, then load idx1 = 32'h06400083, then request addr 0x4 with resp_ready = 1 -> resp_valid the next cycle, resp_data = 32'h06400083, resp_err = 0.
REQ-035 Hold resp_ready = 0 and issue requests at 0x0, 0x4 and 0x8 -> first two accepted, req_ready = 0 on the third; then resp_ready = 1 -> data returned in order 0x13, 0x06400083, and the third request is then accepted.
REQ-036 Request addr 0x42 -> resp_data = 32'h00000013, resp_err = 1, err_count = 1; request addr 0x6 -> data of idx1, resp_err = 1, err_count = 2.
REQ-037 Load idx2 = 32'h00102223 in the same cycle as an accepted request to 0x8 -> response 32'h00000013; the next request to 0x8 -> 32'h00102223.
REQ-038 Assert reset_n = 0 with 2 entries queued -> resp_valid = 0 the next cycle, counters 0, all words read back as 32'h00000013.
REQ-039 Issue 65535 accepted requests, then 2 more -> req_count remains 16'hFFFF.

Source files
------------

// File: rtl/sodor_mem_pkg.sv
// Shared constants and types for the Sodor instruction-memory responder.
// Holds the NOP fill word, default depth, address-field positions and queue entry type.
package sodor_mem_pkg;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
  localparam int unsigned DEPTH_DEFAULT = 16;

  // Byte address layout: [1:0] alignment, [5:2] word index, [31:6] must be zero.
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_MSB = 5;
  localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned HI_LSB  = 6;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_entry_t;

endpackage

// File: rtl/sodor_resp_fifo.sv
// Small response queue with synchronous active-low reset.
// Pointers wrap modulo QDEPTH, so non-power-of-two depths are allowed.
module sodor_resp_fifo
  import sodor_mem_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_entry_t head
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  resp_entry_t         entries_q [QDEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(QDEPTH));
  assign empty   = (count_q == '0);
  assign head    = entries_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        entries_q[wr_ptr_q] <= push_entry;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sodor_imem_responder.sv
// Instruction memory with a load port and a queued fetch-response path.
// Fetches read the array combinationally and enqueue {data, err} at the accepting edge.
module sodor_imem_responder #(
  parameter int unsigned DEPTH    = sodor_mem_pkg::DEPTH_DEFAULT,
  parameter logic [31:0] NOP_WORD = sodor_mem_pkg::NOP_WORD,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        load_valid,
  input  logic [3:0]  load_idx,
  input  logic [31:0] load_data,
  output logic [15:0] req_count,
  output logic [7:0]  err_count
);
  import sodor_mem_pkg::*;

  logic [31:0]      mem_q [DEPTH];
  logic [15:0]      req_count_q;
  logic [7:0]       err_count_q;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range, rd_misaligned, accept;
  resp_entry_t      rd_entry, fifo_head;
  logic             fifo_full, fifo_empty;

  assign rd_idx        = req_addr[IDX_MSB:IDX_LSB];
  assign rd_misaligned = (req_addr[IDX_LSB-1:0] != '0);
  assign rd_in_range   = (req_addr[31:HI_LSB] == '0) && (32'(rd_idx) < DEPTH);

  always_comb begin
    rd_entry      = '0;
    rd_entry.data = rd_in_range ? mem_q[rd_idx] : NOP_WORD;
    rd_entry.err  = !rd_in_range || rd_misaligned;
  end

  // Outputs are forced idle while reset is held, regardless of queue contents.
  assign req_ready  = reset_n && !fifo_full;
  assign resp_valid = reset_n && !fifo_empty;
  assign resp_data  = resp_valid ? fifo_head.data : '0;
  assign resp_err   = resp_valid && fifo_head.err;
  assign accept     = req_valid && req_ready;
  assign req_count  = req_count_q;
  assign err_count  = err_count_q;

  sodor_resp_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_entry(rd_entry),
    .pop       (resp_valid && resp_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The read above uses the pre-edge array, so a same-cycle load is read-before-write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
      req_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (load_valid && (32'(load_idx) < DEPTH)) begin
        mem_q[load_idx] <= load_data;
      end
      if (accept) begin
        if (req_count_q != '1) req_count_q <= req_count_q + 16'd1;
        if (rd_entry.err && (err_count_q != '1)) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule
